// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: writes one 21x21 frame of RGB pixels into sprite RAM as 4-bit palette indices
module sprite_ram_loader #(
  parameter int NUM_PIXELS = 441,
  parameter int ADDR_W     = 9,
  parameter int IDX_W      = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [23:0]       pix_color,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IDX_W-1:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              miss,
  output logic [ADDR_W-1:0] miss_count
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FINISH = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] SAT  = ADDR_W'(NUM_PIXELS);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d, miss_cnt_q, miss_cnt_d;
  logic [IDX_W-1:0]  wr_data_q, wr_data_d, idx;
  logic              wr_en_q, wr_en_d, miss_q, miss_d, hit, take, clr;
  // lowest index wins; unmatched colours become transparent index 0
  always_comb begin
    idx = pix_color == 24'h800080 ? IDX_W'(0) :
          pix_color == 24'hF83800 ? IDX_W'(1) :
          pix_color == 24'hEA9A30 ? IDX_W'(2) :
          pix_color == 24'hEF9D34 ? IDX_W'(3) :
          pix_color == 24'h227DBB ? IDX_W'(4) :
          pix_color == 24'hFFA440 ? IDX_W'(5) :
          pix_color == 24'hAC7C00 ? IDX_W'(6) : IDX_W'(0);
    hit = pix_color inside {24'h800080, 24'hF83800, 24'hEA9A30, 24'hEF9D34,
                            24'h227DBB, 24'hFFA440, 24'hAC7C00};
  end
  // a pixel accepted on the abort edge is dropped, never written
  assign take = pix_valid && state_q == LOAD && !abort;
  assign clr  = state_q == IDLE && start;
  always_comb begin
    state_d    = state_q == IDLE ? (start ? LOAD : IDLE) :
                 state_q == LOAD ? (abort ? IDLE : (take && cnt_q == LAST) ? FINISH : LOAD) :
                 IDLE;
    cnt_d      = clr ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    wr_en_d    = take;
    wr_addr_d  = take ? cnt_q : wr_addr_q;
    wr_data_d  = take ? idx : wr_data_q;
    miss_d     = clr ? 1'b0 : (take && !hit) ? 1'b1 : miss_q;
    miss_cnt_d = clr ? '0 : (take && !hit && miss_cnt_q != SAT) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      miss_q     <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign pix_ready  = state_q == LOAD;
  assign busy       = state_q == LOAD;
  assign done       = state_q == FINISH;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign miss       = miss_q;
  assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: directed and random frames checked cycle by cycle against a frame-level reference model
module tb_sprite_ram_loader;
  localparam int NP = 441;
  logic        Clk = 0, Reset_n = 0, start = 0, abort = 0, pix_valid = 0;
  logic [23:0] pix_color = 0;
  logic        pix_ready, wr_en, busy, done, miss;
  logic [8:0]  wr_addr, miss_count;
  logic [3:0]  wr_data;
  always #5 Clk = ~Clk;
  sprite_ram_loader dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
    .pix_color(pix_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .done(done), .miss(miss), .miss_count(miss_count)
  );
  logic [23:0] pal [7] = '{24'h800080, 24'hF83800, 24'hEA9A30, 24'hEF9D34,
                           24'h227DBB, 24'hFFA440, 24'hAC7C00};
  int n_cmp = 0, n_err = 0;
  int ph = 0, cnt = 0, e_wen = 0, e_addr = 0, e_data = 0, e_miss = 0, e_mc = 0;
  function automatic int ref_idx(logic [23:0] c);
    for (int i = 0; i < 7; i++) if (pal[i] == c) return i;
    return -1;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic step(bit s, bit a, bit v, logic [23:0] c, bit r = 1);
    int idx;
    start = s; abort = a; pix_valid = v; pix_color = c; Reset_n = r;
    @(posedge Clk);
    if (!r) begin
      ph = 0; cnt = 0; e_wen = 0; e_miss = 0; e_mc = 0;
    end else if (ph == 0) begin
      e_wen = 0;
      if (s) begin ph = 1; cnt = 0; e_miss = 0; e_mc = 0; end
    end else if (ph == 2) begin
      e_wen = 0; ph = 0;
    end else if (a) begin
      e_wen = 0; ph = 0;
    end else if (v) begin
      idx = ref_idx(c);
      e_wen = 1; e_addr = cnt; e_data = idx < 0 ? 0 : idx;
      if (idx < 0) begin e_miss = 1; if (e_mc < NP) e_mc++; end
      if (cnt == NP - 1) ph = 2;
      cnt++;
    end else e_wen = 0;
    @(negedge Clk);
    chk("pix_ready", 32'(pix_ready), 32'(ph == 1));
    chk("busy", 32'(busy), 32'(ph == 1));
    chk("done", 32'(done), 32'(ph == 2));
    chk("wr_en", 32'(wr_en), 32'(e_wen));
    if (e_wen != 0) begin
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
    end
    chk("miss", 32'(miss), 32'(e_miss));
    chk("miss_count", 32'(miss_count), 32'(e_mc));
  endtask
  initial begin
    repeat (3) step(0, 0, 1, 24'hF83800, 0);
    repeat (3) step(0, 0, 1, 24'hF83800);
    step(1, 0, 0, 0);
    repeat (NP) step(0, 0, 1, 24'hF83800);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2000 && ph != 0; i++) step(0, 0, i % 2 == 0, pal[cnt % 7]);
    chk("palette_frame_end", 32'(ph), 32'd0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2000 && ph != 0; i++)
      step(0, 0, $urandom_range(3) != 0, (cnt == 3 || cnt == 10) ? 24'h123456 : pal[$urandom_range(6)]);
    chk("miss_frame_mc", 32'(miss_count), 32'd2);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 300 && cnt < 100; i++) step(0, 0, 1, pal[$urandom_range(6)]);
    step(0, 1, 1, pal[2]);
    step(0, 0, 1, pal[2]);
    step(1, 0, 0, 0);
    for (int i = 0; i < 600 && cnt < 200; i++) step(0, 0, $urandom_range(1), $urandom_range(1) ? pal[$urandom_range(6)] : 24'($urandom));
    step(0, 0, 1, pal[4], 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 200 && cnt < 50; i++) step(0, 0, 1, pal[5]);
    step(1, 0, 1, pal[1]);
    step(0, 0, 1, pal[3]);
    step(0, 0, 1, pal[6]);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(15) == 0, $urandom_range(399) == 0, $urandom_range(3) != 0,
           $urandom_range(4) != 0 ? pal[$urandom_range(6)] : 24'($urandom), $urandom_range(1999) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
Stream-to-sprite-memory writer for the on-chip sprite stores.
- Accepts a raster-ordered stream of 24-bit RGB pixels over a valid/ready handshake.
- Encodes each pixel into the 4-bit palette index used by the sprite ROM/RAM readers.
- Issues sequential writes covering one full 21x21 sprite frame.
- Sits between a pixel source (SD/JTAG loader or DMA) and the write port of a sprite RAM, whose read port feeds the color mapper.

Parameters:
NUM_PIXELS, 441, pixels per sprite frame (21x21); address range 0..NUM_PIXELS-1
ADDR_W, 9, write address width; must satisfy 2^ADDR_W >= NUM_PIXELS
IDX_W, 4, palette index width written to memory

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset_n  input  1  synchronous active-low reset
start  input  1  begin loading a frame; honoured only in IDLE
abort  input  1  cancel an in-progress load
pix_color  input  24  RGB pixel, 8 bits per channel, R in [23:16]
pix_valid  input  1  pix_color holds a valid pixel
pix_ready  output  1  block can accept a pixel this cycle
wr_addr  output  ADDR_W  sprite RAM write address
wr_data  output  IDX_W  palette index to write
wr_en  output  1  write strobe, one cycle per pixel
busy  output  1  high in LOAD state
done  output  1  one-cycle pulse marking frame complete
miss  output  1  sticky: at least one pixel in this frame matched no palette entry
miss_count  output  ADDR_W  number of unmatched pixels in current/last frame

Behaviour:
Interface: one clock, Clk; reset is synchronous, active-low, Reset_n.

Reset and state:
- Reset values: pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, miss=0, miss_count=0; FSM=IDLE; pixel counter=0.
- FSM states: IDLE, LOAD, FINISH.
- IDLE:
  - pix_ready=0.
  - start=1 -> LOAD. Same edge clears the pixel counter, miss and miss_count.
  - abort ignored in IDLE.
- LOAD:
  - busy=1; pix_ready=1 combinationally from state.
  - A transfer occurs on a rising edge where pix_valid && pix_ready.
  - pix_valid low -> no transfer, counter holds, no write.
- Per transfer:
  - Pixel is encoded and registered; the following cycle has wr_en=1, wr_addr=counter value at accept, wr_data=index.
  - Counter increments.
  - Write latency: exactly 1 cycle after accept.
  - Back-to-back accepts give consecutive wr_en cycles with consecutive addresses, no bubbles.
- Final pixel: the transfer with counter==NUM_PIXELS-1 moves LOAD -> FINISH.
  - pix_ready=0 from the next cycle; no further pixels accepted.
- FINISH, one cycle:
  - The last write (wr_addr=NUM_PIXELS-1) is presented.
  - done=1 in this same cycle; busy=0.
  - Then -> IDLE.
- wr_en is low in every cycle not immediately following an accept.
- start in LOAD/FINISH is ignored.

Encoding:
- Exact 24-bit equality against the fixed palette, priority to the lowest index:
  0:800080, 1:F83800, 2:EA9A30, 3:EF9D34, 4:227DBB, 5:FFA440, 6:AC7C00.
- No match -> wr_data=0 (transparent), miss set sticky, miss_count +1.
- miss_count saturates at NUM_PIXELS (cannot exceed it in a frame).
- miss and miss_count hold after done until the next accepted start.

Abort:
- abort=1 in LOAD -> IDLE next edge.
- A pixel accepted on that same edge is dropped: no write is issued for it.
- A write already registered from the previous accept still completes, i.e. wr_en may be high one cycle after abort.
- No done pulse. Counter resets on the next start.
- abort in FINISH is ignored: the frame is already complete.

Reset_n=0 mid-load:
- Next edge forces reset values regardless of state.
- Any pending write is discarded (wr_en=0).

Test Plan:
- Reset held 3 cycles then released, pix_valid=1 -> pix_ready=0, wr_en=0, all outputs 0, no writes until start.
- start pulse, then 441 pixels back-to-back, all F83800 -> 441 consecutive wr_en cycles, addr 0..440, data 1; done=1 exactly with addr 440 write; miss=0; busy low afterwards.
- Pixels cycling through all 7 palette colors with pix_valid toggling 1/0 -> writes only after valid cycles, addr increments only on accepts, data sequence 0..6 repeating; done after the 441st accept.
- Frame with pixels 3 and 10 = 123456 -> wr_data=0 at addr 3 and 10, miss=1, miss_count=2 after done; a new start clears both.
- abort asserted while counter=100 and pix_valid=1 -> no write for addr 100, write for addr 99 still issued, no done, IDLE next cycle; a new start reloads from addr 0.
- Reset_n=0 at counter=200 -> next cycle wr_en=0, busy=0, miss_count=0; start while busy (counter=50) -> ignored, addresses continue 51, 52.
